// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared states, opcodes and defaults for the memory arbiter
package mem_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester's request/response handshake with the arbiter
interface mem_arbiter_if #(
  parameter int DATA_W = mem_ctrl_pkg::DATA_W,
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W
);
  logic valid;
  logic write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ready;
  logic done;
  logic [DATA_W-1:0] rdata;
  modport master(output valid, write, addr, wdata, input ready, done, rdata);
  modport slave(input valid, write, addr, wdata, output ready, done, rdata);
endinterface

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; priority passes to the loser on each grant
module rr_arbiter_2
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic r_prio;
  // lone requester wins; with both asking, the one holding priority wins
  always_comb grant = (req == 2'b11) ? ((r_prio == REQ_B) ? 2'b10 : 2'b01) : req;
  // hand priority to the other requester after every actual grant
  always_ff @(posedge clk or posedge rst)
    if (rst) r_prio <= REQ_A;
    else if (advance && |grant) r_prio <= grant[0] ? REQ_B : REQ_A;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one latch-based memory between two requesters with setup/strobe/release timing
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = mem_ctrl_pkg::DATA_W,
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      a,
  mem_arbiter_if.slave      b,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_bus,
  input  logic [DATA_W-1:0] mem_out_bus,
  output logic              busy
);
  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_who, w_who, w_op, w_sel, w_cap, w_idle;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din, r_a_rdata, r_b_rdata;
  logic [1:0] w_grant;
  assign w_idle = (r_state == IDLE);
  rr_arbiter_2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({b.valid, a.valid}),
    .advance(w_idle),
    .grant  (w_grant)
  );
  assign a.ready = w_idle && w_grant[0];
  assign b.ready = w_idle && w_grant[1];
  assign a.done = (r_state == RELEASE) && (r_who == REQ_A);
  assign b.done = (r_state == RELEASE) && (r_who == REQ_B);
  assign a.rdata = r_a_rdata;
  assign b.rdata = r_b_rdata;
  assign busy = !w_idle;
  // next state; the mem_* registers double as the latched request and move only on transitions
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_who = r_who;
    w_op = mem_op;
    w_sel = mem_select;
    w_addr = mem_address;
    w_din = mem_in_bus;
    w_cap = 1'b0;
    case (r_state)
      IDLE: if (|w_grant) begin
        w_state = SETUP;
        w_who = w_grant[1];
        w_op = w_grant[1] ? b.write : a.write;
        w_addr = w_grant[1] ? b.addr : a.addr;
        w_din = (w_op == OP_READ) ? '0 : (w_grant[1] ? b.wdata : a.wdata);
      end
      SETUP: begin
        w_state = STROBE;
        w_sel = 1'b1;
        w_cnt = CW'(STROBE_CYCLES - 1);
      end
      STROBE: if (r_cnt == '0) begin
        w_state = RELEASE;
        w_sel = 1'b0;
        w_cap = (mem_op == OP_READ);
      end else w_cnt = r_cnt - CW'(1);
      default: w_state = IDLE;
    endcase
  end
  // state and memory-side registers; async reset drops mem_select at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_who <= REQ_A;
      mem_op <= 1'b0;
      mem_select <= 1'b0;
      mem_address <= '0;
      mem_in_bus <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_who <= w_who;
      mem_op <= w_op;
      mem_select <= w_sel;
      mem_address <= w_addr;
      mem_in_bus <= w_din;
    end
  // capture read data on the last strobe edge into the owning requester's register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (w_cap) begin
      if (r_who == REQ_A) r_a_rdata <= mem_out_bus;
      else r_b_rdata <= mem_out_bus;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two DUTs (STROBE_CYCLES 1 and 3) checked against a timeline model plus directed literals
module tb_mem_arbiter;
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  req_t rq [2][2];
  logic [1:0] rdy [2];
  logic [1:0] dn [2];
  logic [7:0] rdat [2][2];
  logic sel [2];
  logic bsy [2];
  logic [2:0] adr_o [2];
  logic op_o [2];
  logic [7:0] din_o [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int S = (d == 0) ? 1 : 3;
    mem_arbiter_if ia ();
    mem_arbiter_if ib ();
    logic mop, msel, mbusy;
    logic [2:0] madr;
    logic [7:0] mdin, mdout;
    logic [7:0] em [8] = '{default: 8'h00};
    logic [7:0] rm [8] = '{default: 8'h00};
    int k = 0;
    logic prio = 1'b0, who = 1'b0, op = 1'b0, ga, gb;
    logic [2:0] ad = '0;
    logic [7:0] din = '0, ra = '0, rb = '0;

    assign ia.valid = rq[d][0].valid;
    assign ia.write = rq[d][0].write;
    assign ia.addr = rq[d][0].addr;
    assign ia.wdata = rq[d][0].wdata;
    assign ib.valid = rq[d][1].valid;
    assign ib.write = rq[d][1].write;
    assign ib.addr = rq[d][1].addr;
    assign ib.wdata = rq[d][1].wdata;
    assign rdy[d] = {ib.ready, ia.ready};
    assign dn[d] = {ib.done, ia.done};
    assign rdat[d][0] = ia.rdata;
    assign rdat[d][1] = ib.rdata;
    assign sel[d] = msel;
    assign bsy[d] = mbusy;
    assign adr_o[d] = madr;
    assign op_o[d] = mop;
    assign din_o[d] = mdin;

    mem_arbiter #(.DATA_W(8), .ADDR_W(3), .STROBE_CYCLES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (ia),
      .b          (ib),
      .mem_op     (mop),
      .mem_select (msel),
      .mem_address(madr),
      .mem_in_bus (mdin),
      .mem_out_bus(mdout),
      .busy       (mbusy)
    );

    assign mdout = em[madr];
    always @(posedge clk) if (msel && mop) em[madr] <= mdin;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("d%0d_rst_sel", d), int'(msel), 0);
        chk($sformatf("d%0d_rst_busy", d), int'(mbusy), 0);
        chk($sformatf("d%0d_rst_ready", d), int'(rdy[d]), 0);
        chk($sformatf("d%0d_rst_done", d), int'(dn[d]), 0);
        chk($sformatf("d%0d_rst_rdata_a", d), int'(ia.rdata), 0);
        chk($sformatf("d%0d_rst_rdata_b", d), int'(ib.rdata), 0);
        chk($sformatf("d%0d_rst_mem", d), int'({mop, madr, mdin}), 0);
        k = 0;
        prio = 1'b0;
        ra = '0;
        rb = '0;
      end else begin
        ga = (k == 0) && rq[d][0].valid && (!rq[d][1].valid || !prio);
        gb = (k == 0) && rq[d][1].valid && (!rq[d][0].valid || prio);
        chk($sformatf("d%0d_ready_a", d), int'(ia.ready), int'(ga));
        chk($sformatf("d%0d_ready_b", d), int'(ib.ready), int'(gb));
        chk($sformatf("d%0d_busy", d), int'(mbusy), int'(k != 0));
        chk($sformatf("d%0d_select", d), int'(msel), int'(k >= 2 && k <= S + 1));
        chk($sformatf("d%0d_done_a", d), int'(ia.done), int'(k == S + 2 && !who));
        chk($sformatf("d%0d_done_b", d), int'(ib.done), int'(k == S + 2 && who));
        chk($sformatf("d%0d_rdata_a", d), int'(ia.rdata), int'(ra));
        chk($sformatf("d%0d_rdata_b", d), int'(ib.rdata), int'(rb));
        if (k != 0) begin
          chk($sformatf("d%0d_mem_op", d), int'(mop), int'(op));
          chk($sformatf("d%0d_mem_addr", d), int'(madr), int'(ad));
          chk($sformatf("d%0d_mem_in", d), int'(mdin), int'(din));
        end
        if (k == 0) begin
          if (ga || gb) begin
            who = gb;
            op = gb ? rq[d][1].write : rq[d][0].write;
            ad = gb ? rq[d][1].addr : rq[d][0].addr;
            din = op ? (gb ? rq[d][1].wdata : rq[d][0].wdata) : 8'h00;
            prio = !gb;
            k = 1;
          end
        end else begin
          if (k == 2 && op) rm[ad] = din;
          if (k == S + 1 && !op) begin
            if (who) rb = rm[ad];
            else ra = rm[ad];
          end
          k = (k == S + 2) ? 0 : k + 1;
        end
      end
    end
  end

  task automatic do_req(input int d, input int r, input logic w, input logic [2:0] ad, input logic [7:0] dt);
    int n;
    rq[d][r] = '{1'b1, w, ad, dt};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[d][r] && n < 20);
    chk("req_accept", int'(rdy[d][r]), 1);
    @(posedge clk);
    #1 rq[d][r].valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn[d][r] && n < 20);
    chk("req_done", int'(dn[d][r]), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ma, mb;
    logic [7:0] sm, dm;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) rq[i][j] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(bsy[0]), 0);
    chk("reset_sel", int'(sel[1]), 0);
    chk("reset_rdata", int'(rdat[0][0]), 0);
    @(posedge clk);
    #1 rq[0][0] = '{1'b1, 1'b1, 3'd5, 8'hA5};
    @(negedge clk);
    chk("t1_ready_c0", int'(rdy[0]), 1);
    @(posedge clk);
    #1 rq[0][0].valid = 1'b0;
    @(negedge clk);
    chk("t1_sel_c1", int'(sel[0]), 0);
    @(negedge clk);
    chk("t1_sel_c2", int'(sel[0]), 1);
    chk("t1_bus_c2", int'({op_o[0], adr_o[0], din_o[0]}), int'({1'b1, 3'd5, 8'hA5}));
    @(negedge clk);
    chk("t1_sel_c3", int'(sel[0]), 0);
    chk("t1_done_c3", int'(dn[0]), 1);
    @(posedge clk);
    #1;
    do_req(0, 0, 1'b0, 3'd5, 8'h00);
    chk("t2_a_rdata", int'(rdat[0][0]), 8'hA5);
    chk("t2_b_rdata", int'(rdat[0][1]), 0);
    do_req(0, 1, 1'b1, 3'd3, 8'h33);
    rq[0][0] = '{1'b1, 1'b1, 3'd1, 8'h11};
    rq[0][1] = '{1'b1, 1'b1, 3'd2, 8'h22};
    ma = '0;
    mb = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ma[i] = rdy[0][0];
      mb[i] = rdy[0][1];
    end
    @(posedge clk);
    #1 rq[0][0].valid = 1'b0;
    rq[0][1].valid = 1'b0;
    chk("t3_grants_a", int'(ma), 16'h0101);
    chk("t3_grants_b", int'(mb), 16'h1010);
    repeat (4) @(posedge clk);
    #1;
    do_req(0, 0, 1'b0, 3'd1, 8'h00);
    chk("t3_read_a", int'(rdat[0][0]), 8'h11);
    do_req(0, 1, 1'b0, 3'd2, 8'h00);
    chk("t3_read_b", int'(rdat[0][1]), 8'h22);
    do_req(1, 1, 1'b1, 3'd7, 8'h7E);
    rq[1][1] = '{1'b1, 1'b0, 3'd7, 8'h00};
    @(negedge clk);
    chk("t4_ready_b", int'(rdy[1]), 2);
    @(posedge clk);
    #1 rq[1][1].valid = 1'b0;
    sm = '0;
    dm = '0;
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      sm[c] = sel[1];
      dm[c] = dn[1][1];
    end
    chk("t4_sel_cycles", int'(sm), 8'h1C);
    chk("t4_done_cycle", int'(dm), 8'h20);
    @(posedge clk);
    #1 chk("t4_b_rdata", int'(rdat[1][1]), 8'h7E);
    rq[1][0] = '{1'b1, 1'b0, 3'd7, 8'h00};
    @(negedge clk);
    chk("t5_ready_a", int'(rdy[1]), 1);
    @(posedge clk);
    #1 rq[1][0].valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_sel_before", int'(sel[1]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_sel_async", int'(sel[1]), 0);
    chk("t5_busy_async", int'(bsy[1]), 0);
    chk("t5_done_async", int'(dn[1]), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_done", int'(dn[1]), 0);
    end
    @(posedge clk);
    #1;
    chk("t5_a_rdata_cleared", int'(rdat[1][0]), 0);
    do_req(1, 0, 1'b0, 3'd7, 8'h00);
    chk("t5_a_rdata", int'(rdat[1][0]), 8'h7E);
    rq[0][1] = '{1'b1, 1'b0, 3'd3, 8'h00};
    @(negedge clk);
    chk("t6_ready_b", int'(rdy[0]), 2);
    @(posedge clk);
    #1 rq[0][1].valid = 1'b0;
    rq[0][0] = '{1'b1, 1'b1, 3'd6, 8'hFF};
    @(posedge clk);
    #1 rq[0][0].valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_b_rdata", int'(rdat[0][1]), 8'h33);
    do_req(0, 0, 1'b0, 3'd6, 8'h00);
    chk("t6_mem_untouched", int'(rdat[0][0]), 0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
